// File: rtl/band_gain_mixer.sv
// band_gain_mixer: per-band signed gain, time-multiplexed MAC, rounded and saturated mix of the filter bank outputs.
// Optional feature: define MIXER_SAT_CNT_EN to add the saturating sat_count output.
module band_gain_mixer #(
   parameter int NBANDS = 10,
   parameter int DW     = 24,
   parameter int GW     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 sample_valid,
   input  logic [NBANDS*DW-1:0] band_in,
   input  logic                 gain_we,
   input  logic [3:0]           gain_addr,
   input  logic [GW-1:0]        gain_wdata,
   output logic [DW-1:0]        audio_out,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 sat_flag,
`ifdef MIXER_SAT_CNT_EN
   output logic [15:0]          sat_count,
`endif
   output logic                 overrun
);
   localparam int AW   = DW + GW + 4;
   localparam int PW   = DW + GW;
   localparam int FRAC = GW - 4;
   localparam logic signed [GW-1:0] UNITY = GW'(1) << FRAC;
   localparam logic signed [AW-1:0] HALF  = AW'(1) << (FRAC - 1);
   localparam logic signed [AW-1:0] MAXV  = (AW'(1) << (DW - 1)) - AW'(1);
   localparam logic signed [AW-1:0] MINV  = ~MAXV;
   typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;
   state_t                 state;
   logic [3:0]             idx;
   logic signed [AW-1:0]   acc;
   logic signed [DW-1:0]   cap     [NBANDS];
   logic signed [GW-1:0]   g_stage [NBANDS];
   logic signed [GW-1:0]   g_act   [NBANDS];
   logic signed [PW-1:0]   prod;
   logic signed [AW-1:0]   prod_x;
   logic signed [AW-1:0]   rnd;
   logic                   hi;
   logic                   lo;
   logic                   last;
   logic [DW-1:0]          sat_val;
   assign prod    = cap[idx] * g_act[idx];
   assign prod_x  = {{(AW-PW){prod[PW-1]}}, prod};
   assign rnd     = (acc + HALF) >>> FRAC;
   assign hi      = rnd > MAXV;
   assign lo      = rnd < MINV;
   assign last    = idx == 4'(NBANDS - 1);
   assign sat_val = hi ? MAXV[DW-1:0] : lo ? MINV[DW-1:0] : rnd[DW-1:0];
   // Staging gains: writes land here at any time and are picked up at the next capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NBANDS; i++) g_stage[i] <= UNITY;
      end else if (gain_we && gain_addr < 4'(NBANDS)) begin
         g_stage[gain_addr] <= gain_wdata;
      end
   end
   // Sequencer: capture samples and gains, one band MAC per clock, then round/clamp into the output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         acc       <= '0;
         audio_out <= '0;
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
         for (int i = 0; i < NBANDS; i++) begin
            cap[i]   <= '0;
            g_act[i] <= UNITY;
         end
      end else begin
         out_valid <= 1'b0;
         sat_flag  <= 1'b0;
         if (sample_valid && enable && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: if (sample_valid && enable) begin
               state <= MAC;
               busy  <= 1'b1;
               idx   <= '0;
               acc   <= '0;
               g_act <= g_stage;
               for (int i = 0; i < NBANDS; i++) cap[i] <= band_in[i*DW +: DW];
            end
            MAC: begin
               acc   <= acc + prod_x;
               idx   <= last ? idx : idx + 4'd1;
               state <= last ? SAT : MAC;
            end
            SAT: begin
               state     <= IDLE;
               busy      <= 1'b0;
               audio_out <= sat_val;
               out_valid <= 1'b1;
               sat_flag  <= hi | lo;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef MIXER_SAT_CNT_EN
   // Clip counter: counts clipped outputs and sticks at all-ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sat_count <= '0;
      else if (state == SAT && (hi | lo) && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_band_gain_mixer.sv
// tb_band_gain_mixer: directed checks of the band gain mixer with hand-computed results.
module tb_band_gain_mixer;
   logic          clk;
   logic          reset;
   logic          enable;
   logic          sample_valid;
   logic [239:0]  band_in;
   logic          gain_we;
   logic [3:0]    gain_addr;
   logic [15:0]   gain_wdata;
   logic [23:0]   audio_out;
   logic          out_valid;
   logic          busy;
   logic          sat_flag;
   logic          overrun;
`ifdef MIXER_SAT_CNT_EN
   logic [15:0]   sat_count;
`endif
   int cmp;
   int errs;

   band_gain_mixer dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .sample_valid(sample_valid),
      .band_in(band_in),
      .gain_we(gain_we),
      .gain_addr(gain_addr),
      .gain_wdata(gain_wdata),
      .audio_out(audio_out),
      .out_valid(out_valid),
      .busy(busy),
      .sat_flag(sat_flag),
`ifdef MIXER_SAT_CNT_EN
      .sat_count(sat_count),
`endif
      .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      cmp++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic set_band(input int i, input logic [23:0] v);
      band_in[i*24 +: 24] = v;
   endtask

   task automatic clear_bands();
      band_in = '0;
   endtask

   task automatic wr_gain(input logic [3:0] a, input logic [15:0] d);
      gain_we = 1'b1;
      gain_addr = a;
      gain_wdata = d;
      @(negedge clk);
      gain_we = 1'b0;
   endtask

   task automatic run_sample(input string tag, input logic [23:0] ea, input logic es);
      int n;
      sample_valid = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      gain_we = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      n = 0;
      while (!out_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, 11);
      chk({tag, "_audio"}, audio_out, ea);
      chk({tag, "_sat"}, sat_flag, es);
      chk({tag, "_busy_low"}, busy, 0);
      @(negedge clk);
      chk({tag, "_pulse"}, out_valid, 0);
      chk({tag, "_hold"}, audio_out, ea);
   endtask

   initial begin
      int nv;
      logic [23:0] av;
      cmp = 0;
      errs = 0;
      reset = 1'b1;
      enable = 1'b0;
      sample_valid = 1'b0;
      band_in = '0;
      gain_we = 1'b0;
      gain_addr = '0;
      gain_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_audio", audio_out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sat", sat_flag, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b0;
      @(negedge clk);

      clear_bands();
      set_band(0, 24'h001000);
      run_sample("unity_b0", 24'h001000, 1'b0);

      sample_valid = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      sample_valid = 1'b0;
      nv = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) nv++;
      end
      chk("en_low_no_out", nv, 0);
      chk("en_low_no_ovr", overrun, 0);

      for (int i = 0; i < 10; i++) set_band(i, 24'h100000);
      run_sample("clip_pos", 24'h7FFFFF, 1'b1);
      for (int i = 0; i < 10; i++) set_band(i, 24'hF00000);
      run_sample("clip_neg", 24'h800000, 1'b1);

      for (int i = 0; i < 10; i++) wr_gain(4'(i), (i == 3) ? 16'h0800 : 16'h0000);
      for (int i = 0; i < 10; i++) set_band(i, 24'h000007);
      set_band(3, 24'h000003);
      run_sample("half_p3", 24'h000002, 1'b0);
      set_band(3, 24'hFFFFFD);
      run_sample("half_m3", 24'hFFFFFF, 1'b0);

      for (int i = 0; i < 10; i++) wr_gain(4'(i), 16'h1000);
      clear_bands();
      set_band(9, 24'd100);
      gain_we = 1'b1;
      gain_addr = 4'd9;
      gain_wdata = 16'h2000;
      run_sample("wr_capture", 24'd100, 1'b0);
      run_sample("wr_next", 24'd200, 1'b0);
      wr_gain(4'd12, 16'h0000);
      for (int i = 0; i < 9; i++) set_band(i, 24'd1);
      run_sample("wr_oob", 24'd209, 1'b0);

      clear_bands();
      set_band(0, 24'h000500);
      sample_valid = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (4) @(negedge clk);
      set_band(0, 24'h000700);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      enable = 1'b0;
      chk("ovr_set", overrun, 1);
      nv = 0;
      av = '0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) begin
            nv++;
            av = audio_out;
         end
      end
      chk("ovr_one_out", nv, 1);
      chk("ovr_first_val", av, 24'h000500);
      chk("ovr_sticky", overrun, 1);

      clear_bands();
      set_band(0, 24'h000123);
      sample_valid = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_audio", audio_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ovr", overrun, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_sat", sat_flag, 0);
      @(negedge clk);
      reset = 1'b0;
      nv = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) nv++;
      end
      chk("mid_rst_no_out", nv, 0);
      clear_bands();
      set_band(0, 24'd5);
      set_band(9, 24'd100);
      run_sample("post_rst", 24'd105, 1'b0);

`ifdef MIXER_SAT_CNT_EN
      chk("satcnt_zero", sat_count, 0);
      for (int i = 0; i < 10; i++) set_band(i, 24'h100000);
      run_sample("cnt1", 24'h7FFFFF, 1'b1);
      run_sample("cnt2", 24'h7FFFFF, 1'b1);
      run_sample("cnt3", 24'h7FFFFF, 1'b1);
      chk("satcnt_three", sat_count, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule

// File: doc/band_gain_mixer.md
# band_gain_mixer

Recombination stage of the digital equalizer, downstream of the 10-band FIR filter bank. It captures one sample from each band output, applies a programmable signed gain per band, and sums the results into one 24-bit audio sample. A single time-multiplexed multiply-accumulate unit processes one band per clock, and the sum is rounded and saturated. Typical placement is between the filter bank and the audio output serializer.

## Interface
- NBANDS, 10: number of bands. Band 0 is low-pass, bands 1–8 are 64 Hz…16 kHz, band 9 is high-pass.
- DW, 24: sample width, signed two's complement.
- GW, 16: gain width, signed Q4.12 (unity = 16'h1000).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  accept new samples when high.
- sample_valid  in  1  one-cycle strobe; band_in is valid in the same cycle.
- band_in  in  NBANDS*DW  packed band samples; band i occupies [i*DW +: DW].
- gain_we  in  1  gain write strobe.
- gain_addr  in  4  band index to write.
- gain_wdata  in  GW  gain value to write.
- audio_out  out  DW  mixed, saturated sample (registered).
- out_valid  out  1  one-cycle pulse when audio_out updates.
- busy  out  1  high whenever state ≠ IDLE.
- sat_flag  out  1  one-cycle pulse, coincident with out_valid, when the output clipped.
- overrun  out  1  sticky; a sample was dropped. Cleared only by reset.

## Operation
- FSM states:
  - IDLE → MAC when sample_valid && enable.
  - MAC → MAC while idx < NBANDS-1.
  - MAC → SAT when idx == NBANDS-1.
  - SAT → IDLE unconditionally.
- Capture edge (leaving IDLE):
  - latch all of band_in into a capture register;
  - copy the staging gain bank into the active gain bank;
  - clear acc; set idx = 0.
- MAC edges: acc += band[idx] * gain_active[idx] (full signed product, DW+GW bits); idx++.
- acc width = DW+GW+4 = 44 bits, so it cannot overflow for NBANDS ≤ 16.
- SAT edge:
  - r = (acc + 2^11) >>> 12 (arithmetic shift; round half toward +∞);
  - clamp r to [−2^23, 2^23−1];
  - audio_out ← clamped value; out_valid ← 1; sat_flag ← (clamp applied).
- Gain writes:
  - When gain_we is high and gain_addr < NBANDS, the staging gain at gain_addr is written on that edge, in any state.
  - If gain_addr ≥ NBANDS, the write is ignored.
  - A write in the same cycle as a capture is not visible to that sample; the copy uses the pre-write staging value.
- sample_valid with enable high while busy: the sample is dropped, overrun is set, and the in-flight computation is unaffected.
- sample_valid with enable low: ignored; no overrun.
- enable deasserted mid-computation: the current sample completes normally.
- Reset, including mid-computation:
  - FSM returns to IDLE and acc is cleared;
  - audio_out = 0, out_valid = 0, sat_flag = 0, overrun = 0, busy = 0;
  - all staging and active gains = 16'h1000.

## Timing
- Capture at edge E0. MAC at edges E1…E_NBANDS. SAT at edge E_(NBANDS+1).
- out_valid is high for exactly one cycle after E_(NBANDS+1). Latency = NBANDS+1 = 11 clocks.
- busy is high from after E0 until E_(NBANDS+1); it is low in the cycle where out_valid is high.
- A sample_valid in the out_valid cycle is accepted. Maximum throughput is one sample per NBANDS+2 = 12 clocks.
- audio_out holds its value between out_valid pulses.

## Configuration
- MIXER_SAT_CNT_EN defined:
  - adds output sat_count[15:0], reset to 0;
  - increments on every sat_flag pulse and saturates at 16'hFFFF (no wrap).
- MIXER_SAT_CNT_EN undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Unity gains, band0 = 24'h001000, other bands 0, one strobe → out_valid 11 clocks later, audio_out = 24'h001000, sat_flag = 0.
- Unity gains, all ten bands = 24'h100000 → audio_out = 24'h7FFFFF, sat_flag = 1. All bands = 24'hF00000 → audio_out = 24'h800000, sat_flag = 1.
- gain[3] = 16'h0800 (0.5), other gains 0:
  - band3 = 3 → audio_out = 2;
  - band3 = −3 → audio_out = −1 (round half up).
- Gain write: write gain[9] = 16'h2000 in the capture cycle with band9 = 100, then send a second strobe → first output = 100, second output = 200. A write to gain_addr = 12 changes nothing.
- Overrun: second strobe 5 clocks after the first → overrun = 1 and stays 1; exactly one out_valid with the first sample's result. A strobe with enable = 0 produces no output and no overrun.
- Reset asserted at MAC idx = 4 → all outputs 0 immediately and no out_valid follows. After release, a new strobe produces a correct result with unity gains. With MIXER_SAT_CNT_EN, three clipping samples give sat_count = 3.
